// File: rtl/uart_rx_fifo_if.sv
// Host-side bundle for the UART receiver: serial input, FIFO pop and status.
// The slave modport is the receiver; the master modport is the reader.
interface uart_rx_fifo_if #(
    parameter int unsigned DBIT = 8
);
    logic            rx;
    logic            rd_uart;
    logic [DBIT-1:0] r_data;
    logic            rx_empty;
    logic            rx_full;
    logic            frame_err;
    logic            overrun;

    modport slave (
        input  rx,
        input  rd_uart,
        output r_data,
        output rx_empty,
        output rx_full,
        output frame_err,
        output overrun
    );

    modport master (
        output rx,
        output rd_uart,
        input  r_data,
        input  rx_empty,
        input  rx_full,
        input  frame_err,
        input  overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// 16x-oversampling 8N1 UART receiver feeding a small first-word-fall-through FIFO.
// Bad stop bits and bytes arriving while full are dropped and flagged with 1-cycle pulses.
module uart_rx_fifo #(
    parameter int unsigned DBIT     = 8,
    parameter int unsigned SB_TICK  = 16,
    parameter int unsigned DVSR     = 326,
    parameter int unsigned DVSR_BIT = 9,
    parameter int unsigned FIFO_W   = 2
) (
    input logic           clk,
    input logic           rst,
    uart_rx_fifo_if.slave uart_io
);
    localparam int unsigned Depth = 2 ** FIFO_W;
    localparam int unsigned NW    = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam int unsigned SW    = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StData  = 2'd2;
    localparam logic [1:0] StStop  = 2'd3;

    logic                rx_meta_q, rx_sync_q;
    logic [DVSR_BIT-1:0] div_q, div_d;
    logic                tick;
    logic [1:0]          state_q, state_d;
    logic [SW-1:0]       s_q, s_d;
    logic [NW-1:0]       n_q, n_d;
    logic [DBIT-1:0]     b_q, b_d;
    logic                byte_done, bad_stop;

    logic [DBIT-1:0]     mem_q [Depth];
    logic [FIFO_W-1:0]   wp_q, wp_d, rp_q, rp_d;
    logic                full_q, full_d, empty_q, empty_d;
    logic                ferr_q, ovr_q;
    logic                wr_en, rd_en, ovr_d;

    assign tick  = (div_q == DVSR_BIT'(DVSR - 1));
    assign div_d = tick ? '0 : div_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        n_d       = n_q;
        b_d       = b_q;
        byte_done = 1'b0;
        bad_stop  = 1'b0;
        case (state_q)
            StIdle: begin
                if (!rx_sync_q) begin
                    state_d = StStart;
                    s_d     = '0;
                end
            end
            StStart: begin
                if (tick) begin
                    if (s_q == SW'(7)) begin
                        // Mid-start-bit check rejects short glitches on the line.
                        state_d = rx_sync_q ? StIdle : StData;
                        s_d     = '0;
                        n_d     = '0;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    if (s_q == SW'(15)) begin
                        s_d = '0;
                        b_d = {rx_sync_q, b_q[DBIT-1:1]};
                        if (n_q == NW'(DBIT - 1)) begin
                            state_d = StStop;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: begin
                if (tick) begin
                    if (s_q == SW'(SB_TICK - 1)) begin
                        state_d   = StIdle;
                        byte_done = rx_sync_q;
                        bad_stop  = !rx_sync_q;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
        endcase
    end

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign wr_en = byte_done && (!full_q || uart_io.rd_uart);
    assign rd_en = uart_io.rd_uart && !empty_q;
    assign ovr_d = byte_done && full_q && !uart_io.rd_uart;

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        full_d  = full_q;
        empty_d = empty_q;
        case ({wr_en, rd_en})
            2'b01: begin
                rp_d    = rp_q + 1'b1;
                full_d  = 1'b0;
                empty_d = ((rp_q + 1'b1) == wp_q);
            end
            2'b10: begin
                wp_d    = wp_q + 1'b1;
                empty_d = 1'b0;
                full_d  = ((wp_q + 1'b1) == rp_q);
            end
            2'b11: begin
                wp_d = wp_q + 1'b1;
                rp_d = rp_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            div_q     <= '0;
            state_q   <= StIdle;
            s_q       <= '0;
            n_q       <= '0;
            b_q       <= '0;
            wp_q      <= '0;
            rp_q      <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rx_meta_q <= uart_io.rx;
            rx_sync_q <= rx_meta_q;
            div_q     <= div_d;
            state_q   <= state_d;
            s_q       <= s_d;
            n_q       <= n_d;
            b_q       <= b_d;
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            ferr_q    <= bad_stop;
            ovr_q     <= ovr_d;
            if (wr_en) begin
                mem_q[wp_q] <= b_q;
            end
        end
    end

    assign uart_io.r_data    = mem_q[rp_q];
    assign uart_io.rx_empty  = empty_q;
    assign uart_io.rx_full   = full_q;
    assign uart_io.frame_err = ferr_q;
    assign uart_io.overrun   = ovr_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed frame scenarios plus a random frame phase,
// all compared against a queue-based model of the receive FIFO.
module tb_uart_rx_fifo;
    localparam int unsigned DBIT      = 8;
    localparam int unsigned DVSR      = 4;
    localparam int unsigned BitClk    = 16 * DVSR;
    localparam int unsigned DoneTicks = 8 + 16 * DBIT + 16;
    localparam int unsigned Depth     = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    uart_rx_fifo_if #(.DBIT(DBIT)) uart_if ();

    uart_rx_fifo #(
        .DBIT    (DBIT),
        .SB_TICK (16),
        .DVSR    (DVSR),
        .DVSR_BIT(3),
        .FIFO_W  (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .uart_io(uart_if.slave)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int          ferr_cnt = 0;
    int          ovr_cnt  = 0;
    int          both_cnt = 0;
    int          exp_ferr = 0;
    int          exp_ovr  = 0;
    int unsigned edges;
    logic [7:0]  mq [$];

    // Clock edges since reset release: the tick divider free-runs from this origin.
    always @(posedge clk or negedge rst) begin
        if (!rst) edges <= 0;
        else      edges <= edges + 1;
    end

    always @(negedge clk) begin
        if (uart_if.frame_err) ferr_cnt <= ferr_cnt + 1;
        if (uart_if.overrun)   ovr_cnt  <= ovr_cnt + 1;
        if (uart_if.frame_err && uart_if.overrun) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_state(input string tag);
        #2;
        check({tag, "/empty"}, uart_if.rx_empty, mq.size() == 0);
        check({tag, "/full"}, uart_if.rx_full, mq.size() == Depth);
        if (mq.size() > 0) check({tag, "/r_data"}, uart_if.r_data, mq[0]);
        check({tag, "/frame_err_cnt"}, ferr_cnt, exp_ferr);
        check({tag, "/overrun_cnt"}, ovr_cnt, exp_ovr);
        check({tag, "/both_pulse"}, both_cnt, 0);
    endtask

    task automatic drive_frame(input logic [7:0] b, input bit stop_ok);
        uart_if.rx = 1'b0;
        repeat (BitClk) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_if.rx = b[i];
            repeat (BitClk) @(negedge clk);
        end
        if (stop_ok) begin
            uart_if.rx = 1'b1;
            repeat (BitClk) @(negedge clk);
        end else begin
            // Low across the stop sample point, released well before the next start check.
            uart_if.rx = 1'b0;
            repeat (48) @(negedge clk);
            uart_if.rx = 1'b1;
            repeat (16) @(negedge clk);
        end
    endtask

    // Locates the cycle holding the final stop-bit tick: 2 sync flops + IDLE decision,
    // then 8 start + 16*DBIT data + 16 stop ticks.
    task automatic watch_done(input bit do_rd, input bit chk_push);
        int n = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4000; k++) begin
            if (edges % DVSR == DVSR - 1) n++;
            if (n == DoneTicks) break;
            @(posedge clk);
            #1;
        end
        check("done_tick_found", n, DoneTicks);
        if (chk_push) check("empty_in_done_cycle", uart_if.rx_empty, 1);
        if (do_rd) uart_if.rd_uart = 1'b1;
        @(posedge clk);
        #1;
        uart_if.rd_uart = 1'b0;
        if (chk_push) check("empty_after_push", uart_if.rx_empty, 0);
    endtask

    task automatic frame(input logic [7:0] b, input bit stop_ok, input bit do_rd,
                         input bit chk_push);
        bit full_before;
        @(negedge clk);
        fork
            drive_frame(b, stop_ok);
            watch_done(do_rd, chk_push);
        join
        full_before = (mq.size() == Depth);
        if (do_rd && mq.size() > 0) void'(mq.pop_front());
        if (!stop_ok)                     exp_ferr++;
        else if (full_before && !do_rd)   exp_ovr++;
        else                              mq.push_back(b);
        check_state("frame");
    endtask

    task automatic pop();
        @(negedge clk);
        uart_if.rd_uart = 1'b1;
        @(negedge clk);
        uart_if.rd_uart = 1'b0;
        if (mq.size() > 0) void'(mq.pop_front());
        check_state("pop");
    endtask

    task automatic reset_now(input string tag);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check({tag, "/rst_empty"}, uart_if.rx_empty, 1);
        check({tag, "/rst_full"}, uart_if.rx_full, 0);
        check({tag, "/rst_r_data"}, uart_if.r_data, 0);
        check({tag, "/rst_frame_err"}, uart_if.frame_err, 0);
        check({tag, "/rst_overrun"}, uart_if.overrun, 0);
        mq.delete();
        uart_if.rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        uart_if.rx      = 1'b1;
        uart_if.rd_uart = 1'b0;
        reset_now("init");
        check_state("after_reset");

        // 1: two good frames, read both.
        frame(8'h55, 1'b1, 1'b0, 1'b1);
        check("t1_head", uart_if.r_data, 8'h55);
        frame(8'hA3, 1'b1, 1'b0, 1'b0);
        pop();
        check("t1_second", uart_if.r_data, 8'hA3);
        pop();
        check("t1_drained", uart_if.rx_empty, 1);

        // 2: bad stop bit, then a clean frame.
        frame(8'h3C, 1'b0, 1'b0, 1'b0);
        check("t2_still_empty", uart_if.rx_empty, 1);
        frame(8'h81, 1'b1, 1'b0, 1'b1);
        check("t2_next_byte", uart_if.r_data, 8'h81);
        pop();

        // 3: short low glitch is rejected silently.
        @(negedge clk);
        uart_if.rx = 1'b0;
        repeat (5 * DVSR) @(negedge clk);
        uart_if.rx = 1'b1;
        repeat (200) @(negedge clk);
        check_state("glitch");

        // 4: fill, overrun on the fifth byte, drain in order.
        for (int i = 1; i <= 5; i++) frame(8'(i), 1'b1, 1'b0, 1'b0);
        check("t4_full", uart_if.rx_full, 1);
        for (int i = 1; i <= 4; i++) begin
            check("t4_read_order", uart_if.r_data, i);
            pop();
        end

        // 5: pop in the push cycle while full.
        for (int i = 0; i < 4; i++) frame(8'($urandom), 1'b1, 1'b0, 1'b0);
        frame(8'h77, 1'b1, 1'b1, 1'b0);
        check("t5_still_full", uart_if.rx_full, 1);
        for (int i = 0; i < 3; i++) pop();
        check("t5_last", uart_if.r_data, 8'h77);
        pop();

        // 6: reset in the middle of a data phase.
        frame(8'h11, 1'b1, 1'b0, 1'b0);
        frame(8'h22, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        uart_if.rx = 1'b0;
        repeat (BitClk) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            uart_if.rx = 1'(8'hF0 >> i);
            repeat (BitClk) @(negedge clk);
        end
        reset_now("mid_frame");
        frame(8'h12, 1'b1, 1'b0, 1'b1);
        check("t6_after_reset", uart_if.r_data, 8'h12);
        pop();

        // Random frames, stop errors, coincident reads and pops.
        for (int f = 0; f < 14; f++) begin
            frame(8'($urandom), $urandom_range(0, 5) != 0, $urandom_range(0, 3) == 0, 1'b0);
            repeat ($urandom_range(0, 2)) begin
                if ($urandom_range(0, 1) == 1) pop();
            end
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        while (mq.size() > 0) pop();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
